phy_lane_sched: RTL and testbench
=================================

PHY_LANE_SCHED -- requirements
Module: phy_lane_sched

Interface
REQ-001 The block SHALL have parameter IDLE_SYM, default 8'hBC, the symbol driven on data_out when no lane is granted.
REQ-002 The block SHALL have parameter ALIGN_CYCLES, default 4, the number of idle-symbol cycles sent after link activation before scheduling starts (legal range 1..15).
REQ-003 The block SHALL have port clk_4f, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port active, input, 1 bit: link-up indication from the receive-side serial-to-parallel aligner.
REQ-006 The block SHALL have ports valid0..valid3, input, 1 bit each: lane N has a byte pending.
REQ-007 The block SHALL have ports data_in0..data_in3, input, 8 bits each: pending byte of lane N, stable while validN=1.
REQ-008 The block SHALL have ports ready0..ready3, output, 1 bit each: combinational; lane N's byte is consumed at this rising edge.
REQ-009 The block SHALL have port data_out, output, 8 bits: registered byte toward the parallel-to-serial converter.
REQ-010 The block SHALL have port valid_out, output, 1 bit: registered, data_out carries lane data.
REQ-011 The block SHALL have port grant_lane, output, 2 bits: registered index of the lane whose byte is on data_out.
REQ-012 The block SHALL have port state, output, 2 bits: current FSM state (IDLE=0, ALIGN=1, RUN=2).

Function
REQ-013 The FSM SHALL have states IDLE, ALIGN, RUN; state value 3 is unreachable and SHALL decode as IDLE.
REQ-014 IDLE: while active=0, remain; data_out=IDLE_SYM, valid_out=0, all readyN=0; on active=1, go to ALIGN and load the align counter with ALIGN_CYCLES-1.
REQ-015 ALIGN: data_out=IDLE_SYM, valid_out=0, readyN=0; decrement the counter each cycle; after exactly ALIGN_CYCLES cycles in ALIGN, go to RUN.
REQ-016 RUN: each cycle, select the first lane with validN=1 in search order last+1, last+2, last+3, last (mod 4), where last is the most recently granted lane (3 after reset).
REQ-017 On a selection g in RUN, ready_g SHALL be 1 in that cycle only, and at the next edge data_out<=data_in_g, valid_out<=1, grant_lane<=g, last<=g (latency 1 cycle).
REQ-018 At most one readyN SHALL be 1 in any cycle.
REQ-019 In RUN with all validN=0: data_out<=IDLE_SYM, valid_out<=0, grant_lane and last held, all readyN=0.
REQ-020 A continuously valid lane SHALL be granted within 4 consecutive RUN cycles (no starvation).
REQ-021 If active=0 in any ALIGN or RUN cycle, all readyN SHALL be 0 in that cycle and the FSM SHALL go to IDLE at the next edge; no byte is consumed.
REQ-022 Counter wrap: ALIGN_CYCLES=1 SHALL give exactly one ALIGN cycle; the counter SHALL never underflow.

Reset
REQ-023 With reset=0 at a rising edge: state<=IDLE, data_out<=IDLE_SYM, valid_out<=0, grant_lane<=0, last<=3, align counter<=0, optional idle_cnt<=0.
REQ-024 While reset=0, all readyN SHALL be 0 regardless of other inputs; reset mid-RUN SHALL drop any in-flight selection.

Configuration
REQ-025 With macro PHY_SCHED_STATS_EN defined, the block SHALL add output idle_cnt, 16 bits, incremented on each RUN cycle with no grant, saturating at 16'hFFFF, cleared only by reset.
REQ-026 Without PHY_SCHED_STATS_EN, the port idle_cnt and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-027 Reset then active=1 at cycle 0 -> state ALIGN for cycles 1-4, RUN from cycle 5, data_out=8'hBC and valid_out=0 throughout ALIGN.
REQ-028 RUN with all four lanes valid, data_in0..3=8'h10,8'h21,8'h32,8'h43 -> ready0,1,2,3 in successive cycles; data_out 8'h10,8'h21,8'h32,8'h43, then 8'h10 again; grant_lane 0,1,2,3,0.
REQ-029 RUN with only valid2=1 (data 8'hA5) -> ready2 every cycle, data_out=8'hA5, grant_lane=2; deassert valid2 -> next data_out=8'hBC, valid_out=0, grant_lane stays 2.
REQ-030 RUN, last=1, valid0=valid3=1 -> lane 3 granted first, lane 0 next.
REQ-031 active falls during RUN with all lanes valid -> all readyN=0 that cycle, state IDLE next cycle; active reasserted -> 4 ALIGN cycles before first grant.
REQ-032 With PHY_SCHED_STATS_EN, 10 RUN cycles with no valids -> idle_cnt=10; reset=0 for one edge mid-RUN -> idle_cnt=0, state IDLE, valid_out=0.

Source files
------------

// File: rtl/phy_lane_sched.sv
`default_nettype none
// ============================================================================
// Module      : phy_lane_sched
// Description : Four-lane byte scheduler feeding a parallel-to-serial
//               converter. After link-up it sends ALIGN_CYCLES idle symbols,
//               then grants one pending lane per cycle in round-robin order
//               starting after the most recently granted lane.
// Ports       : clk_4f            - single clock, rising edge
//               reset             - synchronous, active-low
//               active            - link-up from the receive-side aligner
//               valid0..3         - lane N has a byte pending
//               data_in0..3       - pending byte of lane N
//               ready0..3         - combinational, lane N consumed this edge
//               data_out          - registered output byte
//               valid_out         - registered, data_out carries lane data
//               grant_lane        - registered index of lane on data_out
//               idle_cnt          - (PHY_SCHED_STATS_EN only) saturating
//                                   count of RUN cycles without a grant
//               state             - FSM state (IDLE=0, ALIGN=1, RUN=2)
// Options     : define PHY_SCHED_STATS_EN to add the idle_cnt statistic.
// Revision    : 1.0 - initial release
// ============================================================================
module phy_lane_sched #(
    parameter logic [7:0] IDLE_SYM     = 8'hBC,
    parameter int         ALIGN_CYCLES = 4
) (
    input  logic        clk_4f,
    input  logic        reset,
    input  logic        active,
    input  logic        valid0,
    input  logic        valid1,
    input  logic        valid2,
    input  logic        valid3,
    input  logic [7:0]  data_in0,
    input  logic [7:0]  data_in1,
    input  logic [7:0]  data_in2,
    input  logic [7:0]  data_in3,
    output logic        ready0,
    output logic        ready1,
    output logic        ready2,
    output logic        ready3,
    output logic [7:0]  data_out,
    output logic        valid_out,
    output logic [1:0]  grant_lane,
`ifdef PHY_SCHED_STATS_EN
    output logic [15:0] idle_cnt,
`endif
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // Counter holds "ALIGN cycles remaining minus one"; RUN is entered when
    // it reads zero, so a load of 0 yields exactly one ALIGN cycle.
    localparam logic [3:0] c_align_load = 4'(ALIGN_CYCLES - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_align_cnt;
    logic [3:0]  w_next_align_cnt;
    logic [1:0]  r_last;
    logic [7:0]  r_data_out;
    logic        r_valid_out;
    logic [1:0]  r_grant_lane;

    logic        w_run_sel;
    logic [3:0]  w_valid_vec;
    logic [7:0]  w_data_arr [4];
    logic        w_grant_found;
    logic [1:0]  w_grant_idx;
    logic [1:0]  w_cand;
    logic        w_take;
    logic [3:0]  w_ready;

    assign w_valid_vec   = {valid3, valid2, valid1, valid0};
    assign w_data_arr[0] = data_in0;
    assign w_data_arr[1] = data_in1;
    assign w_data_arr[2] = data_in2;
    assign w_data_arr[3] = data_in3;

    // Next-state logic. The encoding 3 is never entered; it falls into the
    // default branch and behaves exactly like IDLE.
    always_comb begin
        w_next_state     = r_state;
        w_next_align_cnt = r_align_cnt;
        w_run_sel        = 1'b0;
        case (r_state)
            ST_ALIGN: begin
                if (!active) begin
                    w_next_state = ST_IDLE;
                end else if (r_align_cnt == 4'd0) begin
                    w_next_state = ST_RUN;
                end else begin
                    w_next_align_cnt = r_align_cnt - 4'd1;
                end
            end
            ST_RUN: begin
                if (!active) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_run_sel = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                if (active) begin
                    w_next_state     = ST_ALIGN;
                    w_next_align_cnt = c_align_load;
                end
            end
        endcase
    end

    // Round-robin search: last+1, last+2, last+3, last (2-bit wrap).
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = r_last;
        w_cand        = r_last;
        for (int i = 1; i <= 4; i++) begin
            w_cand = r_last + 2'(i);
            if (!w_grant_found && w_valid_vec[w_cand]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_cand;
            end
        end
    end

    // Reset gating keeps every ready low while reset is asserted.
    assign w_take  = w_run_sel && w_grant_found && reset;
    assign w_ready = w_take ? (4'b0001 << w_grant_idx) : 4'b0000;

    always_ff @(posedge clk_4f) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_align_cnt  <= 4'd0;
            r_last       <= 2'd3;
            r_data_out   <= IDLE_SYM;
            r_valid_out  <= 1'b0;
            r_grant_lane <= 2'd0;
        end else begin
            r_state     <= w_next_state;
            r_align_cnt <= w_next_align_cnt;
            if (w_take) begin
                r_data_out   <= w_data_arr[w_grant_idx];
                r_valid_out  <= 1'b1;
                r_grant_lane <= w_grant_idx;
                r_last       <= w_grant_idx;
            end else begin
                r_data_out  <= IDLE_SYM;
                r_valid_out <= 1'b0;
            end
        end
    end

`ifdef PHY_SCHED_STATS_EN
    logic [15:0] r_idle_cnt;

    always_ff @(posedge clk_4f) begin
        if (!reset) begin
            r_idle_cnt <= 16'd0;
        end else if ((r_state == ST_RUN) && !w_take && (r_idle_cnt != 16'hFFFF)) begin
            r_idle_cnt <= r_idle_cnt + 16'd1;
        end
    end

    assign idle_cnt = r_idle_cnt;
`endif

    assign ready0     = w_ready[0];
    assign ready1     = w_ready[1];
    assign ready2     = w_ready[2];
    assign ready3     = w_ready[3];
    assign data_out   = r_data_out;
    assign valid_out  = r_valid_out;
    assign grant_lane = r_grant_lane;
    assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_phy_lane_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_phy_lane_sched
// Description : Self-checking bench for phy_lane_sched. Directed scenarios
//               followed by randomized traffic, all compared against a
//               cycle-level behavioural model of the scheduler.
// Options     : define PHY_SCHED_STATS_EN to also check idle_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_phy_lane_sched;

    localparam logic [7:0] IDLE_SYM     = 8'hBC;
    localparam int         ALIGN_CYCLES = 4;

    logic        clk_4f = 1'b0;
    logic        reset;
    logic        active;
    logic [3:0]  tb_valid;
    logic [7:0]  tb_data [4];
    logic        ready0, ready1, ready2, ready3;
    logic [7:0]  data_out;
    logic        valid_out;
    logic [1:0]  grant_lane;
    logic [1:0]  state;
`ifdef PHY_SCHED_STATS_EN
    logic [15:0] idle_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: 0=IDLE 1=ALIGN 2=RUN
    int          m_state      = 0;
    int          m_align_left = 0;
    int          m_last       = 3;
    logic [7:0]  m_dout       = IDLE_SYM;
    logic        m_vout       = 1'b0;
    logic [1:0]  m_glane      = 2'd0;
    int          m_idle       = 0;
    int          wait_cnt [4] = '{0, 0, 0, 0};

    phy_lane_sched #(
        .IDLE_SYM     (IDLE_SYM),
        .ALIGN_CYCLES (ALIGN_CYCLES)
    ) dut (
        .clk_4f     (clk_4f),
        .reset      (reset),
        .active     (active),
        .valid0     (tb_valid[0]),
        .valid1     (tb_valid[1]),
        .valid2     (tb_valid[2]),
        .valid3     (tb_valid[3]),
        .data_in0   (tb_data[0]),
        .data_in1   (tb_data[1]),
        .data_in2   (tb_data[2]),
        .data_in3   (tb_data[3]),
        .ready0     (ready0),
        .ready1     (ready1),
        .ready2     (ready2),
        .ready3     (ready3),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .grant_lane (grant_lane),
`ifdef PHY_SCHED_STATS_EN
        .idle_cnt   (idle_cnt),
`endif
        .state      (state)
    );

    always #5 clk_4f = ~clk_4f;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // First pending lane after 'last' in round-robin order, -1 if none.
    function automatic int pick(input logic [3:0] v, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (v[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    // One clock: inputs are already applied after a falling edge.
    task automatic do_cycle();
        int         exp_sel;
        logic [3:0] exp_ready;
        logic [3:0] obs_ready;
        #1;
        exp_sel   = (reset && active && m_state == 2) ? pick(tb_valid, m_last) : -1;
        exp_ready = (exp_sel >= 0) ? (4'b0001 << exp_sel) : 4'b0000;
        obs_ready = {ready3, ready2, ready1, ready0};
        check("ready", {12'd0, obs_ready}, {12'd0, exp_ready});

        for (int i = 0; i < 4; i++) begin
            if (reset && active && m_state == 2 && tb_valid[i]) begin
                if (obs_ready[i]) wait_cnt[i] = 0;
                else              wait_cnt[i]++;
                if (wait_cnt[i] >= 4)
                    check("starvation", 16'(wait_cnt[i]), 16'd3);
            end else begin
                wait_cnt[i] = 0;
            end
        end

        if (!reset) begin
            m_state = 0; m_dout = IDLE_SYM; m_vout = 1'b0;
            m_glane = 2'd0; m_last = 3; m_idle = 0;
        end else begin
            case (m_state)
                0: begin
                    m_dout = IDLE_SYM; m_vout = 1'b0;
                    if (active) begin
                        m_state = 1; m_align_left = ALIGN_CYCLES;
                    end
                end
                1: begin
                    m_dout = IDLE_SYM; m_vout = 1'b0;
                    if (!active) begin
                        m_state = 0;
                    end else begin
                        m_align_left--;
                        if (m_align_left == 0) m_state = 2;
                    end
                end
                default: begin
                    if (exp_sel >= 0) begin
                        m_dout  = tb_data[exp_sel];
                        m_vout  = 1'b1;
                        m_glane = 2'(exp_sel);
                        m_last  = exp_sel;
                    end else begin
                        m_dout = IDLE_SYM; m_vout = 1'b0;
                        if (m_idle < 65535) m_idle++;
                    end
                    if (!active) m_state = 0;
                end
            endcase
        end

        @(posedge clk_4f);
        #1;
        check("state",      {14'd0, state},      16'(m_state));
        check("data_out",   {8'd0, data_out},    {8'd0, m_dout});
        check("valid_out",  {15'd0, valid_out},  {15'd0, m_vout});
        check("grant_lane", {14'd0, grant_lane}, {14'd0, m_glane});
`ifdef PHY_SCHED_STATS_EN
        check("idle_cnt",   idle_cnt,            16'(m_idle));
`endif
        @(negedge clk_4f);
    endtask

    initial begin
        reset    = 1'b0;
        active   = 1'b0;
        tb_valid = 4'b0000;
        for (int i = 0; i < 4; i++) tb_data[i] = 8'h00;
        @(negedge clk_4f);

        // Reset with traffic present: nothing may be consumed.
        tb_valid = 4'b1111;
        do_cycle();
        do_cycle();
        check("rst_state", {14'd0, state}, 16'd0);
        check("rst_dout",  {8'd0, data_out}, {8'd0, IDLE_SYM});
        tb_valid = 4'b0000;

        // Link-up: ALIGN_CYCLES idle cycles, then RUN.
        reset  = 1'b1;
        active = 1'b1;
        for (int c = 0; c < ALIGN_CYCLES; c++) begin
            do_cycle();
            check("align_state", {14'd0, state}, 16'd1);
            check("align_vout",  {15'd0, valid_out}, 16'd0);
        end
        do_cycle();
        check("run_entry", {14'd0, state}, 16'd2);

        // All lanes valid: strict rotation 0,1,2,3,0.
        tb_data[0] = 8'h10; tb_data[1] = 8'h21; tb_data[2] = 8'h32; tb_data[3] = 8'h43;
        tb_valid   = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            do_cycle();
            check("rr_lane", {14'd0, grant_lane}, 16'(c % 4));
        end

        // Single lane 2 streaming, then dropping out.
        tb_valid   = 4'b0100;
        tb_data[2] = 8'hA5;
        for (int c = 0; c < 3; c++) begin
            do_cycle();
            check("solo_data", {8'd0, data_out}, 16'h00A5);
        end
        tb_valid = 4'b0000;
        do_cycle();
        check("solo_idle_lane", {14'd0, grant_lane}, 16'd2);
        check("solo_idle_sym",  {8'd0, data_out}, {8'd0, IDLE_SYM});

        // last=1, lanes 0 and 3 pending: 3 first, then 0.
        tb_valid = 4'b0010;
        do_cycle();
        tb_valid = 4'b1001;
        do_cycle();
        check("wrap_first", {14'd0, grant_lane}, 16'd3);
        do_cycle();
        check("wrap_second", {14'd0, grant_lane}, 16'd0);

        // Link drop mid-RUN, then re-align.
        tb_valid = 4'b1111;
        active   = 1'b0;
        do_cycle();
        check("drop_state", {14'd0, state}, 16'd0);
        active = 1'b1;
        for (int c = 0; c < ALIGN_CYCLES + 1; c++) do_cycle();
        do_cycle();
        check("realign_grant", {15'd0, valid_out}, 16'd1);

`ifdef PHY_SCHED_STATS_EN
        // Fresh statistics: 10 idle RUN cycles.
        reset = 1'b0;
        do_cycle();
        reset    = 1'b1;
        tb_valid = 4'b0000;
        for (int c = 0; c < ALIGN_CYCLES + 1; c++) do_cycle();
        for (int c = 0; c < 10; c++) do_cycle();
        check("idle_cnt10", idle_cnt, 16'd10);
`endif

        // One-edge reset mid-RUN with traffic pending.
        tb_valid = 4'b1111;
        reset    = 1'b0;
        do_cycle();
        check("midrst_state", {14'd0, state}, 16'd0);
        check("midrst_vout",  {15'd0, valid_out}, 16'd0);
        reset = 1'b1;

        // Randomized traffic with occasional link drops and resets.
        for (int c = 0; c < 600; c++) begin
            reset    = ($urandom_range(0, 99) != 0);
            active   = ($urandom_range(0, 24) != 0);
            tb_valid = 4'($urandom);
            if ($urandom_range(0, 3) == 0) tb_valid = 4'b1111;
            for (int i = 0; i < 4; i++) tb_data[i] = 8'($urandom);
            do_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
